// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared encodings for the ALU issue arbiter
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   typedef enum logic [2:0] {
      F3_ADD  = 3'd0,
      F3_SLL  = 3'd1,
      F3_SLT  = 3'd2,
      F3_SLTU = 3'd3,
      F3_XOR  = 3'd4,
      F3_SR   = 3'd5,
      F3_OR   = 3'd6,
      F3_AND  = 3'd7
   } funct3_e;

   // True for the two opcodes the shared ALU actually implements
   function automatic logic is_alu_op(input logic [6:0] opcode);
      return (opcode == OP_REG) || (opcode == OP_IMM);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant from an external pointer
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx
);

   logic [IDX_W-1:0] w_pos;
   logic             w_found;

   // Scan upward from the pointer with wrap and grant the first active request
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!w_found && i_req[w_pos]) begin
            w_found        = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - shares one ALU among requesters; ALU_ARB_PERF_EN adds perf counters
module alu_issue_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*7-1:0]     i_req_opcode,
   input  logic [NUM_REQ*3-1:0]     i_req_funct3,
   input  logic [NUM_REQ*7-1:0]     i_req_funct7,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_rs1,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_rs2,
   input  logic [NUM_REQ*12-1:0]    i_req_imm,
   input  logic [NUM_REQ*5-1:0]     i_req_shamt,
   input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
   output logic [WIDTH-1:0]         o_alu_rs1,
   output logic [WIDTH-1:0]         o_alu_rs2,
   output logic [2:0]               o_alu_funct3,
   output logic [6:0]               o_alu_funct7,
   output logic [6:0]               o_alu_opcode,
   output logic [11:0]              o_alu_imm,
   output logic [4:0]               o_alu_shamt,
   input  logic [WIDTH-1:0]         i_alu_rd,
   output logic [NUM_REQ-1:0]       o_rsp_valid,
   input  logic [NUM_REQ-1:0]       i_rsp_ready,
   output logic [WIDTH-1:0]         o_rsp_data,
   output logic [TAG_W-1:0]         o_rsp_tag,
`ifdef ALU_ARB_PERF_EN
   input  logic                     i_perf_clr,
   output logic [NUM_REQ*32-1:0]    o_perf_grant_cnt,
   output logic [31:0]              o_perf_busy_cnt,
`endif
   output logic                     o_rsp_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e         r_state;
   arb_state_e         w_next;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_accept;

   logic [WIDTH-1:0]   r_alu_rs1;
   logic [WIDTH-1:0]   r_alu_rs2;
   logic [2:0]         r_alu_funct3;
   logic [6:0]         r_alu_funct7;
   logic [6:0]         r_alu_opcode;
   logic [11:0]        r_alu_imm;
   logic [4:0]         r_alu_shamt;
   logic [TAG_W-1:0]   r_tag;
   logic [WIDTH-1:0]   r_rsp_data;
   logic               r_rsp_err;

   function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] idx);
      if (int'(idx) >= NUM_REQ - 1) return '0;
      return idx + 1'b1;
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // State register; reset discards whatever op is in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and request handshake; grants are only offered while idle and out of reset
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      o_req_ready = '0;
      case (r_state)
         IDLE: begin
            if (!i_rst) begin
               o_req_ready = w_grant;
               w_accept    = |w_grant;
            end
            if (w_accept) w_next = EXEC;
         end
         EXEC: w_next = RESP;
         RESP: if (i_rsp_ready[r_owner]) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Response valid is steered only to the requester that owns the op
   always_comb begin
      o_rsp_valid = '0;
      if (r_state == RESP) o_rsp_valid[r_owner] = 1'b1;
   end

   // Operand capture on accept, result capture after the single execute cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_alu_rs1    <= '0;
         r_alu_rs2    <= '0;
         r_alu_funct3 <= '0;
         r_alu_funct7 <= '0;
         r_alu_opcode <= '0;
         r_alu_imm    <= '0;
         r_alu_shamt  <= '0;
         r_tag        <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_rs1    <= i_req_rs1[w_idx*WIDTH +: WIDTH];
            r_alu_rs2    <= i_req_rs2[w_idx*WIDTH +: WIDTH];
            r_alu_funct3 <= i_req_funct3[w_idx*3 +: 3];
            r_alu_funct7 <= i_req_funct7[w_idx*7 +: 7];
            r_alu_opcode <= i_req_opcode[w_idx*7 +: 7];
            r_alu_imm    <= i_req_imm[w_idx*12 +: 12];
            r_alu_shamt  <= i_req_shamt[w_idx*5 +: 5];
            r_tag        <= i_req_tag[w_idx*TAG_W +: TAG_W];
            r_owner      <= w_idx;
            r_rr_ptr     <= f_next_ptr(w_idx);
         end
         if (r_state == EXEC) begin
            r_rsp_data <= i_alu_rd;
            r_rsp_err  <= !is_alu_op(r_alu_opcode);
         end
      end
   end

   assign o_alu_rs1    = r_alu_rs1;
   assign o_alu_rs2    = r_alu_rs2;
   assign o_alu_funct3 = r_alu_funct3;
   assign o_alu_funct7 = r_alu_funct7;
   assign o_alu_opcode = r_alu_opcode;
   assign o_alu_imm    = r_alu_imm;
   assign o_alu_shamt  = r_alu_shamt;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_tag    = r_tag;
   assign o_rsp_err    = r_rsp_err;

`ifdef ALU_ARB_PERF_EN
   logic [NUM_REQ-1:0][31:0] r_grant_cnt;
   logic [31:0]              r_busy_cnt;

   // Free-running wrap-around counters; clear takes priority over counting
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_grant_cnt <= '0;
         r_busy_cnt  <= '0;
      end else if (i_perf_clr) begin
         r_grant_cnt <= '0;
         r_busy_cnt  <= '0;
      end else begin
         if (w_accept)        r_grant_cnt[w_idx] <= r_grant_cnt[w_idx] + 32'd1;
         if (r_state != IDLE) r_busy_cnt         <= r_busy_cnt + 32'd1;
      end
   end

   assign o_perf_grant_cnt = r_grant_cnt;
   assign o_perf_busy_cnt  = r_busy_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter
module tb_alu_issue_arbiter;

   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 2;
   localparam int TAG_W   = 4;
   localparam logic [6:0] C_OP_R = 7'b0110011;
   localparam logic [6:0] C_OP_I = 7'b0010011;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [11:0] imm;
      logic [4:0]  sh;
      logic [3:0]  tag;
   } op_t;

   typedef struct {
      int          owner;
      logic [31:0] data;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic                     clk;
   logic                     rst;
   logic [NUM_REQ-1:0]       i_req_valid;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic [NUM_REQ*7-1:0]     i_req_opcode;
   logic [NUM_REQ*3-1:0]     i_req_funct3;
   logic [NUM_REQ*7-1:0]     i_req_funct7;
   logic [NUM_REQ*WIDTH-1:0] i_req_rs1;
   logic [NUM_REQ*WIDTH-1:0] i_req_rs2;
   logic [NUM_REQ*12-1:0]    i_req_imm;
   logic [NUM_REQ*5-1:0]     i_req_shamt;
   logic [NUM_REQ*TAG_W-1:0] i_req_tag;
   logic [WIDTH-1:0]         o_alu_rs1;
   logic [WIDTH-1:0]         o_alu_rs2;
   logic [2:0]               o_alu_funct3;
   logic [6:0]               o_alu_funct7;
   logic [6:0]               o_alu_opcode;
   logic [11:0]              o_alu_imm;
   logic [4:0]               o_alu_shamt;
   logic [WIDTH-1:0]         alu_rd;
   logic [NUM_REQ-1:0]       o_rsp_valid;
   logic [NUM_REQ-1:0]       i_rsp_ready;
   logic [WIDTH-1:0]         o_rsp_data;
   logic [TAG_W-1:0]         o_rsp_tag;
   logic                     o_rsp_err;
`ifdef ALU_ARB_PERF_EN
   logic                     i_perf_clr;
   logic [NUM_REQ*32-1:0]    o_perf_grant_cnt;
   logic [31:0]              o_perf_busy_cnt;
`endif

   exp_t sb[$];
   op_t  seq [2][10];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tb_ptr   = 0;

   alu_issue_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_opcode (i_req_opcode),
      .i_req_funct3 (i_req_funct3),
      .i_req_funct7 (i_req_funct7),
      .i_req_rs1    (i_req_rs1),
      .i_req_rs2    (i_req_rs2),
      .i_req_imm    (i_req_imm),
      .i_req_shamt  (i_req_shamt),
      .i_req_tag    (i_req_tag),
      .o_alu_rs1    (o_alu_rs1),
      .o_alu_rs2    (o_alu_rs2),
      .o_alu_funct3 (o_alu_funct3),
      .o_alu_funct7 (o_alu_funct7),
      .o_alu_opcode (o_alu_opcode),
      .o_alu_imm    (o_alu_imm),
      .o_alu_shamt  (o_alu_shamt),
      .i_alu_rd     (alu_rd),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_data   (o_rsp_data),
      .o_rsp_tag    (o_rsp_tag),
`ifdef ALU_ARB_PERF_EN
      .i_perf_clr       (i_perf_clr),
      .o_perf_grant_cnt (o_perf_grant_cnt),
      .o_perf_busy_cnt  (o_perf_busy_cnt),
`endif
      .o_rsp_err    (o_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b, input logic [11:0] imm,
                                          input logic [4:0] sh);
      logic [31:0] ib;
      logic [4:0]  s;
      logic        is_r;
      logic [31:0] y;
      is_r = (opc == C_OP_R);
      ib   = is_r ? b : {{20{imm[11]}}, imm};
      s    = is_r ? b[4:0] : sh;
      case (f3)
         3'd0: y = (is_r && f7[5]) ? a - ib : a + ib;
         3'd1: y = a << s;
         3'd2: y = ($signed(a) < $signed(ib)) ? 32'd1 : 32'd0;
         3'd3: y = (a < ib) ? 32'd1 : 32'd0;
         3'd4: y = a ^ ib;
         3'd5: y = f7[5] ? 32'($signed(a) >>> s) : a >> s;
         3'd6: y = a | ib;
         default: y = a & ib;
      endcase
      if (opc != C_OP_R && opc != C_OP_I) y = 32'd0;
      return y;
   endfunction

   // ALU instance the arbiter feeds
   always_comb alu_rd = alu_fn(o_alu_opcode, o_alu_funct3, o_alu_funct7, o_alu_rs1,
                               o_alu_rs2, o_alu_imm, o_alu_shamt);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic op_t rand_op(input logic [3:0] tag);
      op_t o;
      o.opc = ($urandom_range(0, 1) == 1) ? C_OP_R : C_OP_I;
      o.f3  = 3'($urandom_range(0, 7));
      o.f7  = (((o.f3 == 3'd0) && (o.opc == C_OP_R)) || (o.f3 == 3'd5)) &&
              ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      o.rs1 = $urandom;
      o.rs2 = $urandom;
      o.imm = 12'($urandom);
      o.sh  = 5'($urandom);
      o.tag = tag;
      return o;
   endfunction

   function automatic logic [1:0] exp_grant(input logic [1:0] v, input int p);
      if (v[p])     return 2'b01 << p;
      if (v[1 - p]) return 2'b01 << (1 - p);
      return 2'b00;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input op_t op);
      i_req_valid[i]              = 1'b1;
      i_req_opcode[i*7 +: 7]      = op.opc;
      i_req_funct3[i*3 +: 3]      = op.f3;
      i_req_funct7[i*7 +: 7]      = op.f7;
      i_req_rs1[i*WIDTH +: WIDTH] = op.rs1;
      i_req_rs2[i*WIDTH +: WIDTH] = op.rs2;
      i_req_imm[i*12 +: 12]       = op.imm;
      i_req_shamt[i*5 +: 5]       = op.sh;
      i_req_tag[i*TAG_W +: TAG_W] = op.tag;
   endtask

   task automatic push_exp(input int i, input op_t op);
      exp_t e;
      e.owner = i;
      e.data  = alu_fn(op.opc, op.f3, op.f7, op.rs1, op.rs2, op.imm, op.sh);
      e.tag   = op.tag;
      e.err   = !((op.opc == C_OP_R) || (op.opc == C_OP_I));
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req_valid = '0;
      cyc(2);
      rst = 1'b0;
      tb_ptr = 0;
      sb.delete();
   endtask

   // Scoreboard pop on every response handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (o_rsp_valid != '0)) begin
         check("rsp_onehot", 64'($onehot(o_rsp_valid)), 64'd1);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (o_rsp_valid[i] && i_rsp_ready[i]) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 64'(sb.size()), 64'd1);
               end else begin
                  e = sb.pop_front();
                  check("rsp_owner", 64'(i), 64'(e.owner));
                  check("rsp_data", 64'(o_rsp_data), 64'(e.data));
                  check("rsp_tag", 64'(o_rsp_tag), 64'(e.tag));
                  check("rsp_err", 64'(o_rsp_err), 64'(e.err));
               end
            end
         end
      end
   end

   task automatic run_one(input int i, input op_t op);
      int c;
      drive(i, op);
      push_exp(i, op);
      #1;
      c = 0;
      while (!o_req_ready[i] && c < 20) begin cyc(1); c++; end
      check("accept_timeout", 64'(c < 20), 64'd1);
      cyc(1);
      i_req_valid[i] = 1'b0;
      c = 0;
      while (sb.size() != 0 && c < 20) begin cyc(1); c++; end
      check("rsp_timeout", 64'(sb.size()), 64'd0);
      cyc(1);
   endtask

   task automatic run_pair(input int n);
      int          cnt [2];
      int          c;
      logic [1:0]  acc;
      logic [1:0]  eg;
      cnt[0] = 0;
      cnt[1] = 0;
      for (int k = 0; k < n; k++) begin
         push_exp(0, seq[0][k]);
         push_exp(1, seq[1][k]);
      end
      drive(0, seq[0][0]);
      drive(1, seq[1][0]);
      c = 0;
      while ((cnt[0] < n || cnt[1] < n || sb.size() != 0) && c < 400) begin
         #1;
         acc = o_req_ready & i_req_valid;
         if (acc != 2'b00) begin
            eg = exp_grant(i_req_valid, tb_ptr);
            check("rr_grant", 64'(acc), 64'(eg));
            tb_ptr = eg[0] ? 1 : 0;
         end
         cyc(1);
         c++;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               cnt[i]++;
               if (cnt[i] < n) drive(i, seq[i][cnt[i]]);
               else            i_req_valid[i] = 1'b0;
            end
         end
      end
      check("pair_timeout", 64'(c < 400), 64'd1);
      check("pair_cnt0", 64'(cnt[0]), 64'(n));
      check("pair_cnt1", 64'(cnt[1]), 64'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t op;
      op_t op_b;
      op_t op_c;
      logic [31:0] exp_b;

      rst          = 1'b1;
      i_req_valid  = 2'b11;
      i_req_opcode = '0;
      i_req_funct3 = '0;
      i_req_funct7 = '0;
      i_req_rs1    = '0;
      i_req_rs2    = '0;
      i_req_imm    = '0;
      i_req_shamt  = '0;
      i_req_tag    = '0;
      i_rsp_ready  = 2'b11;
`ifdef ALU_ARB_PERF_EN
      i_perf_clr   = 1'b0;
`endif
      cyc(1);
      check("rst_req_ready", 64'(o_req_ready), 64'd0);
      check("rst_alu_rs1", 64'(o_alu_rs1), 64'd0);
      check("rst_alu_opcode", 64'(o_alu_opcode), 64'd0);
      check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(o_rsp_data), 64'd0);
      check("rst_rsp_tag", 64'(o_rsp_tag), 64'd0);
      check("rst_rsp_err", 64'(o_rsp_err), 64'd0);
      do_reset();

      // Single op: 5 + 7, tag 3, latency two edges
      op = '{opc:C_OP_R, f3:3'd0, f7:7'd0, rs1:32'd5, rs2:32'd7, imm:12'd0, sh:5'd0, tag:4'd3};
      drive(0, op);
      push_exp(0, op);
      #1;
      check("t1_ready", 64'(o_req_ready), 64'b01);
      cyc(1);
      i_req_rs1[31:0] = 32'd99;
      #1;
      check("t1_alu_rs1", 64'(o_alu_rs1), 64'd5);
      check("t1_alu_rs2", 64'(o_alu_rs2), 64'd7);
      check("t1_busy_ready", 64'(o_req_ready), 64'd0);
      check("t1_no_early_rsp", 64'(o_rsp_valid), 64'd0);
      cyc(1);
      i_req_valid[0] = 1'b0;
      check("t1_rsp_valid", 64'(o_rsp_valid), 64'b01);
      check("t1_rsp_data", 64'(o_rsp_data), 64'd12);
      check("t1_rsp_tag", 64'(o_rsp_tag), 64'd3);
      check("t1_rsp_err", 64'(o_rsp_err), 64'd0);
      check("t1_alu_hold", 64'(o_alu_rs1), 64'd5);
      cyc(1);
      check("t1_idle", 64'(o_rsp_valid), 64'd0);
      check("t1_sb_empty", 64'(sb.size()), 64'd0);

      // Contention from reset: alternating grants over 20 ops
      do_reset();
      for (int k = 0; k < 10; k++) begin
         seq[0][k] = rand_op(4'(k % 8));
         seq[1][k] = rand_op(4'(8 + k % 8));
      end
      run_pair(10);
      check("t2_sb_empty", 64'(sb.size()), 64'd0);

      // Response backpressure; non-owner ready must not complete the op
      op_b  = rand_op(4'd5);
      exp_b = alu_fn(op_b.opc, op_b.f3, op_b.f7, op_b.rs1, op_b.rs2, op_b.imm, op_b.sh);
      op_c  = '{opc:C_OP_I, f3:3'd0, f7:7'd0, rs1:32'd100, rs2:32'd0, imm:12'd23, sh:5'd0, tag:4'd9};
      i_rsp_ready = 2'b01;
      drive(1, op_b);
      push_exp(1, op_b);
      #1;
      check("t3_ready", 64'(o_req_ready), 64'b10);
      cyc(1);
      i_req_valid[1] = 1'b0;
      drive(0, op_c);
      push_exp(0, op_c);
      #1;
      check("t3_busy_ready", 64'(o_req_ready), 64'd0);
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         check("t3_stall_valid", 64'(o_rsp_valid), 64'b10);
         check("t3_stall_data", 64'(o_rsp_data), 64'(exp_b));
         check("t3_stall_ready", 64'(o_req_ready), 64'd0);
         cyc(1);
      end
      i_rsp_ready = 2'b11;
      #1;
      check("t3_still_valid", 64'(o_rsp_valid), 64'b10);
      cyc(1);
      check("t3_idle_valid", 64'(o_rsp_valid), 64'd0);
      check("t3_next_grant", 64'(o_req_ready), 64'b01);
      cyc(1);
      i_req_valid[0] = 1'b0;
      cyc(3);
      check("t3_sb_empty", 64'(sb.size()), 64'd0);
      check("t3_data_held", 64'(o_rsp_data), 64'd123);

      // Reset during EXEC: everything clears without waiting for a clock
      op = rand_op(4'd7);
      op.rs1 = op.rs1 | 32'h1;
      drive(1, op);
      #1;
      check("t5_ready", 64'(o_req_ready), 64'b10);
      cyc(1);
      i_req_valid[1] = 1'b0;
      check("t5_exec_rs1", 64'(o_alu_rs1), 64'(op.rs1));
      #2;
      rst = 1'b1;
      #1;
      check("t5_alu_rs1", 64'(o_alu_rs1), 64'd0);
      check("t5_alu_opcode", 64'(o_alu_opcode), 64'd0);
      check("t5_rsp_data", 64'(o_rsp_data), 64'd0);
      check("t5_rsp_tag", 64'(o_rsp_tag), 64'd0);
      check("t5_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check("t5_req_ready", 64'(o_req_ready), 64'd0);
      cyc(1);
      rst = 1'b0;
      tb_ptr = 0;
      for (int k = 0; k < 3; k++) begin
         check("t5_no_stale", 64'(o_rsp_valid), 64'd0);
         cyc(1);
      end
      seq[0][0] = rand_op(4'd1);
      seq[1][0] = rand_op(4'd2);
      run_pair(1);

      // Illegal opcode completes with err set and zero data
      op = '{opc:7'h03, f3:3'd2, f7:7'd0, rs1:32'h1234, rs2:32'h55, imm:12'h10, sh:5'd3, tag:4'hA};
      run_one(0, op);

`ifdef ALU_ARB_PERF_EN
      i_perf_clr = 1'b1;
      cyc(1);
      i_perf_clr = 1'b0;
      check("perf_pre_clr", 64'(o_perf_busy_cnt), 64'd0);
      for (int k = 0; k < 3; k++) run_one(1, rand_op(4'(k)));
      check("perf_grant1", 64'(o_perf_grant_cnt[63:32]), 64'd3);
      check("perf_grant0", 64'(o_perf_grant_cnt[31:0]), 64'd0);
      check("perf_busy", 64'(o_perf_busy_cnt), 64'd6);
      i_perf_clr = 1'b1;
      cyc(1);
      i_perf_clr = 1'b0;
      check("perf_clr_grant1", 64'(o_perf_grant_cnt[63:32]), 64'd0);
      check("perf_clr_busy", 64'(o_perf_busy_cnt), 64'd0);
`endif

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Shares one combinational integer ALU (R-type/I-type, outputs RD) between NUM_REQ requesters, such as decode slots or a debug port.
- Per-requester valid/ready request channels; round-robin grant.
- Registers the winning operation into the ALU input registers, captures RD one cycle later.
- Returns the tagged result to the granted requester on a valid/ready response channel.
- Sits between issue logic and the ALU instance; one operation in flight at a time.

Parameters:
WIDTH, 32, datapath width (RS1/RS2/RD)
NUM_REQ, 2, number of requesters, legal 2..4
TAG_W, 4, request tag width, echoed on response

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero)
req_opcode  in  NUM_REQ*7  opcode, slice i = [7i+6:7i]
req_funct3  in  NUM_REQ*3  funct3
req_funct7  in  NUM_REQ*7  funct7
req_rs1  in  NUM_REQ*WIDTH  operand 1
req_rs2  in  NUM_REQ*WIDTH  operand 2
req_imm  in  NUM_REQ*12  immediate
req_shamt  in  NUM_REQ*5  shift amount
req_tag  in  NUM_REQ*TAG_W  requester tag
alu_rs1/alu_rs2  out  WIDTH  registered ALU operands
alu_funct3  out  3  registered funct3
alu_funct7  out  7  registered funct7
alu_opcode  out  7  registered opcode
alu_imm  out  12  registered immediate
alu_shamt  out  5  registered shift amount
alu_rd  in  WIDTH  ALU result (combinational from alu_* outputs)
rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
rsp_ready  in  NUM_REQ  per-requester response ready
rsp_data  out  WIDTH  captured result
rsp_tag  out  TAG_W  tag of the completed request
rsp_err  out  1  opcode was neither 0110011 nor 0010011

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; all alu_* = 0; rsp_valid=0; rsp_data=0; rsp_tag=0; rsp_err=0; req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first requester with req_valid, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - On handshake (valid & ready), register that requester's fields into alu_* and store its tag and index (owner).
  - Update rr_ptr = (owner+1) mod NUM_REQ, then go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_* stable; at the clock edge capture rsp_data=alu_rd and rsp_err = opcode not in {0110011, 0010011}.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_data, rsp_tag and rsp_err are held stable until rsp_ready[owner]=1.
  - On that handshake go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency: request accepted at edge N -> rsp_valid high from cycle N+2. Throughput is at best one op per 3 cycles.
- req_ready=0 in EXEC/RESP, so no new request is accepted while busy.
- alu_* hold their last values outside IDLE-accept, so the ALU input does not toggle.
- Requester request fields are sampled only at acceptance; later changes are ignored.
- Fairness: a requester held valid is granted within NUM_REQ grants.
- Error ops still complete normally, with rsp_data = alu_rd (0 for an unknown opcode).
- rst mid-operation: the in-flight op is discarded, no response is issued, and the state reverts to reset values immediately.

Optional Feature:
Macro ALU_ARB_PERF_EN.
- Defined: adds outputs perf_grant_cnt (NUM_REQ*32, per-requester accepted-op counters) and perf_busy_cnt (32, cycles not in IDLE).
  - Counters reset to 0 and wrap at 2^32.
  - Input perf_clr (1) synchronously zeros all counters; clear wins over increment in the same cycle.
- Undefined: none of these ports or counters exist; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
  - opcode constants OP_REG=7'b0110011, OP_IMM=7'b0010011
  - funct3 names ADD..AND (0..7)
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant and winner index. Purely combinational; rr_ptr lives in the parent.

Test Plan:
- Single op: req0 OP_REG, funct3=0, rs1=5, rs2=7, tag=3; ALU model attached. Accepted at edge N; rsp_valid[0] at N+2; rsp_data=12, rsp_tag=3, rsp_err=0.
- Contention: both requesters valid continuously from reset. Grants alternate 0,1,0,1; each response carries its own tag; no starvation over 20 ops.
- Response backpressure: rsp_ready held 0 for 5 cycles. rsp_valid and rsp_data stay constant; req_ready stays 0; completes the cycle rsp_ready=1; IDLE next cycle.
- Illegal opcode: opcode=7'h03. rsp_err=1, rsp_data=0, normal handshake.
- Reset mid-op: assert rst during EXEC. All outputs go to 0 asynchronously; after release, no stale rsp_valid; next request granted to requester 0.
- ALU_ARB_PERF_EN: 3 ops from req1 with no stalls. perf_grant_cnt[1]=3 and perf_busy_cnt=6; perf_clr then zeros both.
